codificador_7a3: RTL and testbench

Registered 7-to-3 priority encoder. It converts a 7-bit request vector into the 3-bit binary index of its highest asserted line, with code 000 meaning "no request". Status flags report whether any request is present and whether several lines were active at once. It sits between request/interrupt-style line sources and downstream logic that consumes a compact, clock-aligned index.

---
 rtl/codificador_7a3.sv | 59 +++++
 tb/tb_codificador_7a3.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/codificador_7a3.sv
// codificador_7a3: registered 7-to-3 priority encoder
// with request-present and multiple-request flags.
module codificador_7a3 (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] X,
  output logic [2:0] Salida,
  output logic       Valido,
  output logic       Error
);

  logic [2:0] w_code;
  logic       w_any;
  logic       w_multi;
  logic [6:0] w_low_clr;

  logic [2:0] r_code;
  logic       r_valid;
  logic       r_err;

  // Highest set line wins; code is line index plus one.
  always_comb begin
    w_code = 3'd0;
    priority case (1'b1)
      X[6]:    w_code = 3'd7;
      X[5]:    w_code = 3'd6;
      X[4]:    w_code = 3'd5;
      X[3]:    w_code = 3'd4;
      X[2]:    w_code = 3'd3;
      X[1]:    w_code = 3'd2;
      X[0]:    w_code = 3'd1;
      default: w_code = 3'd0;
    endcase
  end

  // Clearing the lowest set bit leaves something
  // only when two or more lines are active.
  assign w_low_clr = X & (X - 7'd1);
  assign w_any     = |X;
  assign w_multi   = |w_low_clr;

  // All three outputs captured from the same sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_code  <= 3'd0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_code  <= w_code;
      r_valid <= w_any;
      r_err   <= w_multi;
    end
  end

  assign Salida = r_code;
  assign Valido = r_valid;
  assign Error  = r_err;

endmodule

// File: tb/tb_codificador_7a3.sv
// tb_codificador_7a3: directed + exhaustive checks
// of the registered priority encoder via a scoreboard.
module tb_codificador_7a3;

  logic       clk;
  logic       rst;
  logic [6:0] X;
  logic [2:0] Salida;
  logic       Valido;
  logic       Error;

  typedef struct packed {
    logic [2:0] code;
    logic       valid;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   n_run;
  int   n_fail;

  codificador_7a3 dut (
    .clk    (clk),
    .rst    (rst),
    .X      (X),
    .Salida (Salida),
    .Valido (Valido),
    .Error  (Error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [6:0] v);
    exp_t e;
    int   cnt;
    e   = '0;
    cnt = 0;
    for (int i = 0; i < 7; i++) begin
      if (v[i]) begin
        cnt++;
        e.code = 3'(i + 1);
      end
    end
    e.valid = (cnt > 0);
    e.err   = (cnt >= 2);
    return e;
  endfunction

  task automatic chk(input string tag,
                     input logic [2:0] obs,
                     input logic [2:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b",
             tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input exp_t e);
    chk({tag, ".Salida"}, Salida, e.code);
    chk({tag, ".Valido"}, {2'b0, Valido}, {2'b0, e.valid});
    chk({tag, ".Error"},  {2'b0, Error},  {2'b0, e.err});
  endtask

  task automatic drive(input logic [6:0] v);
    @(negedge clk);
    X = v;
    q.push_back(model(v));
  endtask

  task automatic sample(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      n_run++;
      n_fail++;
      $error("FAIL %s observed=empty expected=entry", tag);
    end else begin
      e = q.pop_front();
      chk_out(tag, e);
    end
  endtask

  task automatic step(input string tag, input logic [6:0] v);
    drive(v);
    sample(tag);
  endtask

  initial begin
    logic [6:0] sweep [8];
    n_run  = 0;
    n_fail = 0;
    rst    = 1'b1;
    X      = 7'd0;

    #2;
    chk_out("reset_init", '0);
    @(negedge clk);
    rst = 1'b0;

    // directed one-hot sweep including the all-zero ends
    sweep[0] = 7'b0000000;
    sweep[1] = 7'b0000010;
    sweep[2] = 7'b0000100;
    sweep[3] = 7'b0001000;
    sweep[4] = 7'b0010000;
    sweep[5] = 7'b0100000;
    sweep[6] = 7'b1000000;
    sweep[7] = 7'b0000000;
    for (int i = 0; i < 8; i++)
      step($sformatf("sweep%0d", i), sweep[i]);

    step("lowest", 7'b0000001);
    chk("lowest_const", Salida, 3'b001);

    step("multi_0100101", 7'b0100101);
    chk("multi_0100101_c", Salida, 3'b110);
    chk("multi_0100101_e", {2'b0, Error}, 3'd1);
    step("multi_1111111", 7'b1111111);
    chk("multi_1111111_c", Salida, 3'b111);
    step("multi_0000011", 7'b0000011);
    chk("multi_0000011_c", Salida, 3'b010);
    chk("multi_0000011_e", {2'b0, Error}, 3'd1);

    // back-to-back through every input value
    for (int v = 0; v < 128; v++)
      step($sformatf("all_%0d", v), 7'(v));

    // asynchronous reset between edges
    step("pre_reset", 7'b1000000);
    chk("pre_reset_c", Salida, 3'b111);
    #2;
    rst = 1'b1;
    #1;
    chk_out("async_reset", '0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    q.push_back(model(X));
    sample("post_reset");
    chk("post_reset_c", Salida, 3'b111);

    // glitch between edges never reaches outputs
    step("glitch_pre", 7'b0000000);
    @(negedge clk);
    X = 7'b0001000;
    #2;
    X = 7'b0000000;
    q.push_back(model(7'b0000000));
    sample("glitch");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=done");
    $fatal(1, "timeout");
  end

endmodule
